// File: rtl/decode_pkg.sv
// decode_pkg: MIPS32-subset opcodes, funct codes, ALU operation encoding and control bundle
package decode_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26, FN_SLT = 6'h2a;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;
  typedef struct packed {
    alu_op_t alu_op;
    logic    wmem;
    logic    wreg;
    logic    m2reg;
    logic    aluimm;
    logic    shift;
    logic    jal;
    logic    use_rs;
    logic    use_rt;
    logic    beq;
    logic    bne;
    logic    j;
    logic    jr;
  } ctrl_t;
endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: two asynchronous read ports, one synchronous write port, optional hardwired-zero register 0
module decode_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   ra,
  input  logic [AW-1:0]   rb,
  output logic [XLEN-1:0] qa,
  output logic [XLEN-1:0] qb,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);
  logic [XLEN-1:0] mem [NREG];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wen && !(ZERO_REG != 0 && waddr == '0)) begin
      mem[waddr] <= wdata;
    end
  end
  assign qa = ZERO_REG != 0 && ra == '0 ? '0 : mem[ra];
  assign qb = ZERO_REG != 0 && rb == '0 ? '0 : mem[rb];
endmodule

// File: rtl/id_decoder.sv
// id_decoder: combinational instruction decode into control bundle, source/destination registers and immediate
module id_decoder
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW = 5
) (
  input  logic [31:0]     inst,
  output ctrl_t           ctrl,
  output logic [AW-1:0]   rs,
  output logic [AW-1:0]   rt,
  output logic [AW-1:0]   rn,
  output logic [XLEN-1:0] imm
);
  logic [5:0] op, fn;
  logic [XLEN-1:0] sx, zx;
  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign rs = inst[21 +: AW];
  assign rt = inst[16 +: AW];
  assign sx = {{(XLEN-16){inst[15]}}, inst[15:0]};
  assign zx = {{(XLEN-16){1'b0}}, inst[15:0]};
  always_comb begin
    ctrl = '0;
    imm = '0;
    rn = rt;
    case (op)
      OP_R: begin
        rn = inst[11 +: AW];
        case (fn)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT: begin
            ctrl.wreg = 1'b1;
            ctrl.use_rs = 1'b1;
            ctrl.use_rt = 1'b1;
            ctrl.alu_op = fn == FN_ADDU ? ALU_ADD : fn == FN_SUBU ? ALU_SUB : fn == FN_AND ? ALU_AND :
                          fn == FN_OR ? ALU_OR : fn == FN_XOR ? ALU_XOR : ALU_SLT;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            ctrl.wreg = 1'b1;
            ctrl.use_rt = 1'b1;
            ctrl.shift = 1'b1;
            imm = XLEN'(inst[10:6]);
            ctrl.alu_op = fn == FN_SLL ? ALU_SLL : fn == FN_SRL ? ALU_SRL : ALU_SRA;
          end
          FN_JR: begin
            ctrl.jr = 1'b1;
            ctrl.use_rs = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.wreg = 1'b1;
        ctrl.use_rs = 1'b1;
        ctrl.aluimm = 1'b1;
        imm = op == OP_ADDIU ? sx : zx;
        ctrl.alu_op = op == OP_ADDIU ? ALU_ADD : op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : ALU_XOR;
      end
      OP_LUI: begin
        ctrl.wreg = 1'b1;
        ctrl.aluimm = 1'b1;
        ctrl.alu_op = ALU_LUI;
        imm = {inst[15:0], {(XLEN-16){1'b0}}};
      end
      OP_LW: begin
        ctrl.wreg = 1'b1;
        ctrl.m2reg = 1'b1;
        ctrl.aluimm = 1'b1;
        ctrl.use_rs = 1'b1;
        imm = sx;
      end
      OP_SW: begin
        ctrl.wmem = 1'b1;
        ctrl.aluimm = 1'b1;
        ctrl.use_rs = 1'b1;
        ctrl.use_rt = 1'b1;
        imm = sx;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.beq = op == OP_BEQ;
        ctrl.bne = op == OP_BNE;
        ctrl.use_rs = 1'b1;
        ctrl.use_rt = 1'b1;
        ctrl.alu_op = ALU_SUB;
        imm = sx;
      end
      OP_J: ctrl.j = 1'b1;
      OP_JAL: begin
        ctrl.jal = 1'b1;
        ctrl.wreg = 1'b1;
        rn = AW'(31);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: ID stage with register file, EX/MEM/WB forwarding, interlocks, branch resolution and ID/EX register
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int ZERO_REG = 1,
  parameter int WB_BYPASS = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            ex_stall,
  input  logic            id_flush,
  input  logic            ex_wen,
  input  logic            ex_is_load,
  input  logic [AW-1:0]   ex_waddr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            mem_wen,
  input  logic [AW-1:0]   mem_waddr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic            wb_wen,
  input  logic [AW-1:0]   wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            idex_valid,
  output logic [XLEN-1:0] idex_pc,
  output logic [XLEN-1:0] idex_da,
  output logic [XLEN-1:0] idex_db,
  output logic [XLEN-1:0] idex_imm,
  output logic [AW-1:0]   idex_rn,
  output logic [3:0]      idex_alu_op,
  output logic            idex_wmem,
  output logic            idex_wreg,
  output logic            idex_m2reg,
  output logic            idex_aluimm,
  output logic            idex_shift,
  output logic            idex_jal,
  output logic [31:0]     stall_cnt
);
  ctrl_t ctrl;
  logic [AW-1:0] rs, rt, rn;
  logic [XLEN-1:0] imm, rf_a, rf_b, fa, fb, pc4, bpc, jpc;
  logic za, zb, dep, stall, load;
  id_decoder #(.XLEN(XLEN), .AW(AW)) u_dec (.inst(if_inst), .ctrl(ctrl), .rs(rs), .rt(rt), .rn(rn), .imm(imm));
  decode_regfile #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(ZERO_REG)) u_rf (
    .clk(clk), .reset(reset), .ra(rs), .rb(rt), .qa(rf_a), .qb(rf_b),
    .wen(wb_wen), .waddr(wb_waddr), .wdata(wb_wdata)
  );
  assign za = ZERO_REG != 0 && rs == '0;
  assign zb = ZERO_REG != 0 && rt == '0;
  assign fa = za ? '0 : ex_wen && !ex_is_load && ex_waddr == rs ? ex_wdata :
              mem_wen && mem_waddr == rs ? mem_wdata :
              WB_BYPASS != 0 && wb_wen && wb_waddr == rs ? wb_wdata : rf_a;
  assign fb = zb ? '0 : ex_wen && !ex_is_load && ex_waddr == rt ? ex_wdata :
              mem_wen && mem_waddr == rt ? mem_wdata :
              WB_BYPASS != 0 && wb_wen && wb_waddr == rt ? wb_wdata : rf_b;
  // branches resolve in ID, so any in-flight EX producer of their operands forces a wait
  assign dep = ex_wen && (ctrl.use_rs && ex_waddr == rs || ctrl.use_rt && ex_waddr == rt);
  assign stall = if_valid && dep && (ex_is_load || ctrl.beq || ctrl.bne || ctrl.jr) && !id_flush;
  assign id_ready = !stall && !ex_stall;
  assign load = if_valid && !stall && !id_flush;
  assign pc4 = if_pc + XLEN'(4);
  assign bpc = pc4 + (imm << 2);
  assign jpc = {pc4[XLEN-1:28], if_inst[25:0], 2'b00};
  assign redirect = load && !ex_stall &&
                    (ctrl.beq && fa == fb || ctrl.bne && fa != fb || ctrl.j || ctrl.jal || ctrl.jr);
  assign redirect_pc = ctrl.jr ? fa : ctrl.j || ctrl.jal ? jpc : bpc;
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      idex_valid <= 1'b0;
      idex_pc <= '0;
      idex_da <= '0;
      idex_db <= '0;
      idex_imm <= '0;
      idex_rn <= '0;
      idex_alu_op <= '0;
      idex_wmem <= 1'b0;
      idex_wreg <= 1'b0;
      idex_m2reg <= 1'b0;
      idex_aluimm <= 1'b0;
      idex_shift <= 1'b0;
      idex_jal <= 1'b0;
    end else begin
      if (stall && !ex_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (!ex_stall) begin
        idex_valid <= load;
        idex_pc <= load ? if_pc : '0;
        idex_da <= load ? (ctrl.jal ? if_pc + XLEN'(8) : fa) : '0;
        idex_db <= load ? fb : '0;
        idex_imm <= load ? imm : '0;
        idex_rn <= load ? rn : '0;
        idex_alu_op <= load ? ctrl.alu_op : '0;
        idex_wmem <= load && ctrl.wmem;
        idex_wreg <= load && ctrl.wreg;
        idex_m2reg <= load && ctrl.m2reg;
        idex_aluimm <= load && ctrl.aluimm;
        idex_shift <= load && ctrl.shift;
        idex_jal <= load && ctrl.jal;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset, if_valid, id_ready, ex_stall, id_flush, ex_wen, ex_is_load, mem_wen, wb_wen, redirect;
  logic [31:0] if_inst, if_pc, ex_wdata, mem_wdata, wb_wdata, redirect_pc;
  logic [4:0] ex_waddr, mem_waddr, wb_waddr, idex_rn;
  logic idex_valid, idex_wmem, idex_wreg, idex_m2reg, idex_aluimm, idex_shift, idex_jal;
  logic [31:0] idex_pc, idex_da, idex_db, idex_imm, stall_cnt;
  logic [3:0] idex_alu_op;
  int checks = 0, errors = 0;
  typedef struct {string tag; logic bub; logic [31:0] da; logic [4:0] rn; logic wr;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .id_ready(id_ready),
    .ex_stall(ex_stall), .id_flush(id_flush), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
    .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .idex_valid(idex_valid), .idex_pc(idex_pc),
    .idex_da(idex_da), .idex_db(idex_db), .idex_imm(idex_imm), .idex_rn(idex_rn),
    .idex_alu_op(idex_alu_op), .idex_wmem(idex_wmem), .idex_wreg(idex_wreg), .idex_m2reg(idex_m2reg),
    .idex_aluimm(idex_aluimm), .idex_shift(idex_shift), .idex_jal(idex_jal), .stall_cnt(stall_cnt)
  );

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_op(input string tag, input logic [31:0] da, input logic [4:0] rn, input logic wr);
    sb.push_back('{tag, 1'b0, da, rn, wr});
  endtask

  task automatic expect_bub(input string tag);
    sb.push_back('{tag, 1'b1, 32'h0, 5'h0, 1'b0});
  endtask

  task automatic tick;
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_valid"}, 32'(idex_valid), 32'(!e.bub));
      chk({e.tag, "_wreg"}, 32'(idex_wreg), 32'(e.wr));
      if (!e.bub) begin
        chk({e.tag, "_da"}, idex_da, e.da);
        chk({e.tag, "_rn"}, 32'(idex_rn), 32'(e.rn));
      end
    end
  endtask

  initial begin
    reset = 1; if_valid = 0; if_inst = 0; if_pc = 0; ex_stall = 0; id_flush = 0;
    ex_wen = 0; ex_is_load = 0; ex_waddr = 0; ex_wdata = 0;
    mem_wen = 0; mem_waddr = 0; mem_wdata = 0; wb_wen = 0; wb_waddr = 0; wb_wdata = 0;
    expect_bub("rst0"); tick;
    expect_bub("rst1"); tick;
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_da", idex_da, 0);
    chk("rst_pc", idex_pc, 0);
    reset = 0; #1;
    chk("idle_ready", 32'(id_ready), 1);
    chk("idle_redirect", 32'(redirect), 0);
    wb_wen = 1; wb_waddr = 1; wb_wdata = 3; expect_bub("pre1"); tick;
    wb_waddr = 2; expect_bub("pre2"); tick;
    // forwarding priority EX > MEM > WB > register file
    if_valid = 1; if_pc = 32'h200; if_inst = enc_r(3, 0, 4, 0, 6'h21);
    ex_wen = 1; ex_waddr = 3; ex_wdata = 5;
    mem_wen = 1; mem_waddr = 3; mem_wdata = 7;
    wb_wen = 1; wb_waddr = 3; wb_wdata = 9;
    expect_op("fwd_ex", 5, 4, 1); tick;
    ex_wen = 0; expect_op("fwd_mem", 7, 4, 1); tick;
    mem_wen = 0; expect_op("fwd_wb", 9, 4, 1); tick;
    wb_wen = 0; expect_op("fwd_rf", 9, 4, 1); tick;
    chk("fwd_pc", idex_pc, 32'h200);
    // load-use interlock
    ex_wen = 1; ex_is_load = 1; ex_waddr = 5; if_inst = enc_r(5, 5, 6, 0, 6'h21); #1;
    chk("lu_ready", 32'(id_ready), 0);
    expect_bub("lu_bubble"); tick;
    chk("lu_cnt", stall_cnt, 1);
    ex_wen = 0; ex_is_load = 0; mem_wen = 1; mem_waddr = 5; mem_wdata = 32'h1234; #1;
    chk("lu_ready2", 32'(id_ready), 1);
    expect_op("lu_fwd", 32'h1234, 6, 1); tick;
    chk("lu_cnt2", stall_cnt, 1);
    mem_wen = 0;
    // branches
    if_pc = 32'h100; if_inst = enc_i(6'h04, 1, 2, 16'h4); #1;
    chk("beq_redirect", 32'(redirect), 1);
    chk("beq_target", redirect_pc, 32'h114);
    expect_op("beq_idex", 3, 2, 0); tick;
    wb_wen = 1; wb_waddr = 2; wb_wdata = 4; #1;
    chk("beq_not_taken", 32'(redirect), 0);
    expect_op("beq_nt_idex", 3, 2, 0); tick;
    wb_wen = 0; ex_wen = 1; ex_waddr = 1; ex_wdata = 32'hee; #1;
    chk("beq_stall_ready", 32'(id_ready), 0);
    chk("beq_stall_redirect", 32'(redirect), 0);
    expect_bub("beq_bubble"); tick;
    chk("beq_cnt", stall_cnt, 2);
    ex_wen = 0;
    if_pc = 32'h400; if_inst = enc_j(6'h03, 26'h40); #1;
    chk("jal_redirect", 32'(redirect), 1);
    chk("jal_target", redirect_pc, 32'h100);
    expect_op("jal_idex", 32'h408, 31, 1); tick;
    chk("jal_flag", 32'(idex_jal), 1);
    // backpressure hold, then flush overriding a simultaneous load-use
    if_pc = 32'h500; if_inst = enc_i(6'h0d, 1, 7, 16'h10);
    expect_op("ori_idex", 3, 7, 1); tick;
    chk("ori_imm", idex_imm, 32'h10);
    chk("ori_aluimm", 32'(idex_aluimm), 1);
    ex_stall = 1; ex_wen = 1; ex_is_load = 1; ex_waddr = 1; if_inst = enc_r(1, 0, 8, 0, 6'h21);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_ready", 32'(id_ready), 0);
      expect_op("hold", 3, 7, 1); tick;
      chk("hold_cnt", stall_cnt, 2);
      chk("hold_pc", idex_pc, 32'h500);
    end
    ex_stall = 0; id_flush = 1; ex_waddr = 3; if_inst = enc_r(3, 0, 4, 0, 6'h21); #1;
    chk("flush_ready", 32'(id_ready), 1);
    expect_bub("flush"); tick;
    chk("flush_cnt", stall_cnt, 2);
    id_flush = 0; ex_wen = 0; ex_is_load = 0;
    if_inst = enc_i(6'h0f, 0, 8, 16'h1234);
    expect_op("lui_idex", 0, 8, 1); tick;
    chk("lui_imm", idex_imm, 32'h12340000);
    if_inst = enc_i(6'h2b, 1, 2, 16'h8);
    expect_op("sw_idex", 3, 2, 0); tick;
    chk("sw_wmem", 32'(idex_wmem), 1);
    chk("sw_db", idex_db, 4);
    chk("sw_imm", idex_imm, 8);
    // register 0 ignores writes and never forwards
    if_valid = 0; wb_wen = 1; wb_waddr = 0; wb_wdata = 32'hff;
    expect_bub("z_wb"); tick;
    wb_wen = 0; if_valid = 1; if_inst = enc_r(0, 0, 1, 0, 6'h25);
    ex_wen = 1; ex_waddr = 0; ex_wdata = 32'hab; mem_wen = 1; mem_waddr = 0; mem_wdata = 32'hcd;
    expect_op("zero", 0, 1, 1); tick;
    chk("zero_db", idex_db, 0);
    ex_wen = 0; mem_wen = 0; if_valid = 0;
    chk("sb_drain", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
